// File: rtl/gray_fifo_wptr.sv
// Write-side pointer tracker for an async FIFO: binary/Gray write pointer, remote Gray pointer synchroniser, occupancy and full.
// Optional Gray-violation / overrun checking is compiled in with GRAY_FIFO_WPTR_CHECK_EN.
module gray_fifo_wptr #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic [ADDR_W:0]   remote_gray_i,
  output logic              accept_o,
  output logic [ADDR_W:0]   ptr_bin_o,
  output logic [ADDR_W:0]   ptr_gray_o,
  output logic [ADDR_W:0]   remote_bin_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [PW-1:0] ptr_bin_q, ptr_bin_d;
  logic [PW-1:0] ptr_gray_q, ptr_gray_d;
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0] sync_last;
  logic [PW-1:0] remote_bin;
  logic [PW-1:0] count;
  logic          full;
  logic          accept;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Gray is registered alongside binary so the crossing value never glitches.
  always_comb begin
    ptr_bin_d  = ptr_bin_q;
    ptr_gray_d = ptr_gray_q;
    if (accept) begin
      ptr_bin_d  = ptr_bin_q + PW'(1);
      ptr_gray_d = ptr_bin_d ^ (ptr_bin_d >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      sync_q     <= '0;
    end else begin
      ptr_bin_q  <= ptr_bin_d;
      ptr_gray_q <= ptr_gray_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], remote_gray_i};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_decode
      assign remote_bin[gi] = ^sync_last[ADDR_W:gi];
    end
  endgenerate

  assign count  = ptr_bin_q - remote_bin;
  assign full   = (count == DEPTH);
  assign accept = inc_i && !full;

`ifdef GRAY_FIFO_WPTR_CHECK_EN
  logic [PW-1:0] last_prev_q;
  logic [PW-1:0] delta;
  logic          err_q, err_d;

  // More than one bit set in delta means the remote pointer was not a legal Gray step.
  always_comb begin
    delta = sync_last ^ last_prev_q;
    err_d = err_q;
    if (((delta & (delta - PW'(1))) != '0) || (count > DEPTH)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_prev_q <= '0;
      err_q       <= 1'b0;
    end else begin
      last_prev_q <= sync_last;
      err_q       <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign accept_o     = accept;
  assign ptr_bin_o    = ptr_bin_q;
  assign ptr_gray_o   = ptr_gray_q;
  assign remote_bin_o = remote_bin;
  assign count_o      = count;
  assign full_o       = full;

endmodule

// File: tb/tb_gray_fifo_wptr.sv
// Bench for gray_fifo_wptr (ADDR_W=3, SYNC_STAGES=2): directed vector table, corner sequences, random run against an integer model.
module tb_gray_fifo_wptr;

  localparam int AW = 3;
  localparam int PW = AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          inc;
  logic [PW-1:0] rg;
  logic          accept_o;
  logic [PW-1:0] ptr_bin_o, ptr_gray_o, remote_bin_o, count_o;
  logic          full_o, err_o;

  gray_fifo_wptr #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .inc_i        (inc),
    .remote_gray_i(rg),
    .accept_o     (accept_o),
    .ptr_bin_o    (ptr_bin_o),
    .ptr_gray_o   (ptr_gray_o),
    .remote_bin_o (remote_bin_o),
    .count_o      (count_o),
    .full_o       (full_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: write pointer as integer, remote Gray values delayed through two slots.
  int m_wp, m_s0, m_s1;

  function automatic int g2b(input int g);
    int b = 0;
    for (int i = 0; i < PW; i++) b = b ^ (g >> i);
    return b & 15;
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int m_count();
    return (m_wp - g2b(m_s1) + 16) % 16;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state();
    check("ptr_bin", 32'(ptr_bin_o), 32'(m_wp));
    check("ptr_gray", 32'(ptr_gray_o), 32'(b2g(m_wp)));
    check("remote_bin", 32'(remote_bin_o), 32'(g2b(m_s1)));
    check("count", 32'(count_o), 32'(m_count()));
    check("full", 32'(full_o), 32'(m_count() == 8));
`ifndef GRAY_FIFO_WPTR_CHECK_EN
    check("err", 32'(err_o), 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; inc = 1'b0; rg = '0;
    @(posedge clk);
    m_wp = 0; m_s0 = 0; m_s1 = 0;
    #1;
    check_state();
    rst = 1'b0;
  endtask

  task automatic cycle(input logic r, input logic i, input int g);
    logic acc;
    rst = r; inc = i; rg = 4'(g);
    #1;
    acc = i && (m_count() != 8);
    check("accept", 32'(accept_o), 32'(acc));
    @(posedge clk);
    if (r) begin
      m_wp = 0; m_s0 = 0; m_s1 = 0;
    end else begin
      if (acc) m_wp = (m_wp + 1) % 16;
      m_s1 = m_s0;
      m_s0 = g;
    end
    #1;
    check_state();
  endtask

  typedef struct {
    logic          r;
    logic          i;
    logic [PW-1:0] g;
    logic          acc;
    logic [PW-1:0] bin;
    logic [PW-1:0] gray;
    logic [PW-1:0] rb;
    logic [PW-1:0] cnt;
    logic          full;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int wt, rp;
    logic r, i;

    // Expected outputs after each row's edge, inputs still applied.
    tbl[0]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h2, 4'h3, 4'h0, 4'h2, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h3, 4'h2, 4'h0, 4'h3, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h4, 4'h6, 4'h0, 4'h4, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h5, 4'h7, 4'h0, 4'h5, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h6, 4'h5, 4'h0, 4'h6, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h7, 4'h4, 4'h0, 4'h7, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h8, 4'hC, 4'h0, 4'h8, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h8, 4'hC, 4'h0, 4'h8, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'h6, 1'b0, 4'h8, 4'hC, 4'h0, 4'h8, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'h6, 1'b0, 4'h8, 4'hC, 4'h4, 4'h4, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'h6, 1'b1, 4'h9, 4'hD, 4'h4, 4'h5, 1'b0};

    for (int k = 0; k < 14; k++) begin
      rst = tbl[k].r; inc = tbl[k].i; rg = tbl[k].g;
      @(posedge clk);
      #1;
      check("tbl_accept", 32'(accept_o), 32'(tbl[k].acc));
      check("tbl_bin", 32'(ptr_bin_o), 32'(tbl[k].bin));
      check("tbl_gray", 32'(ptr_gray_o), 32'(tbl[k].gray));
      check("tbl_remote", 32'(remote_bin_o), 32'(tbl[k].rb));
      check("tbl_count", 32'(count_o), 32'(tbl[k].cnt));
      check("tbl_full", 32'(full_o), 32'(tbl[k].full));
    end

    // Wrap: 15 pushes with remote trailing, then one more rolls to zero.
    do_reset();
    for (int k = 0; k < 15; k++) cycle(1'b0, 1'b1, b2g(m_wp));
    check("wrap_bin_top", 32'(ptr_bin_o), 32'd15);
    check("wrap_gray_top", 32'(ptr_gray_o), 32'd8);
    cycle(1'b0, 1'b1, b2g(m_wp));
    check("wrap_bin_zero", 32'(ptr_bin_o), 32'd0);
    check("wrap_gray_zero", 32'(ptr_gray_o), 32'd0);

    // Push and remote advance at the same edge, count 3.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 0);
    check("simul_pre", 32'(count_o), 32'd3);
    cycle(1'b0, 1'b1, 1);
    check("simul_push", 32'(count_o), 32'd4);
    cycle(1'b0, 1'b0, 1);
    check("simul_net", 32'(count_o), 32'd3);

`ifdef GRAY_FIFO_WPTR_CHECK_EN
    do_reset();
    cycle(1'b0, 1'b0, 3);
    check("err_edge1", 32'(err_o), 32'd0);
    cycle(1'b0, 1'b0, 3);
    check("err_edge2", 32'(err_o), 32'd0);
    cycle(1'b0, 1'b0, 3);
    check("err_edge3", 32'(err_o), 32'd1);
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);
    check("err_sticky", 32'(err_o), 32'd1);
    do_reset();
    check("err_cleared", 32'(err_o), 32'd0);
`endif

    // Random run: remote read pointer never overtakes total writes.
    do_reset();
    wt = 0;
    rp = 0;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 99) == 0);
      i = ($urandom_range(0, 3) != 0);
      if (r) begin
        wt = 0;
        rp = 0;
        cycle(1'b1, i, 0);
      end else begin
        if ($urandom_range(0, 1) == 1 && rp < wt) rp++;
        if (i && m_count() != 8) wt++;
        cycle(1'b0, i, b2g(rp % 16));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
